// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-side PC sequencer and the execute-stage resolver.
package branch_redirect_ctrl_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned INSTR_BYTES = 4;

    // Jump/branch operation codes as produced by decode.
    typedef enum logic [OP_W-1:0] {
        OpJal  = 3'd0,
        OpJalr = 3'd1,
        OpBeq  = 3'd2,
        OpBne  = 3'd3,
        OpBlt  = 3'd4,
        OpBge  = 3'd5,
        OpBltu = 3'd6,
        OpBgeu = 3'd7
    } jb_op_e;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: sequential fetch, redirect on taken jump/branch, fixed-length
// flush window, misaligned-target trap, link address and redirect counter.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     OPERATION_SIZE = 3,
    parameter logic [XLEN-1:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter int unsigned     FLUSH_DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      ex_valid,
    input  logic [OPERATION_SIZE-1:0] ex_operation,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic [XLEN-1:0]           ex_target,
    output logic [XLEN-1:0]           pc_out,
    output logic                      fetch_valid,
    output logic                      flush,
    output logic [XLEN-1:0]           link_addr,
    output logic                      link_valid,
    output logic                      misaligned,
    output logic [15:0]               redirect_count
);

    localparam int unsigned CntW = $clog2(FLUSH_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] link_addr_q, link_addr_d;
    logic            link_valid_q, link_valid_d;
    logic            misaligned_q, misaligned_d;
    logic [15:0]     redirect_count_q, redirect_count_d;

    logic is_jump;
    logic taken;

    // Classify the resolving instruction; unknown codes fall back to the target compare.
    always_comb begin
        is_jump = (ex_operation == OPERATION_SIZE'(OpJal)) ||
                  (ex_operation == OPERATION_SIZE'(OpJalr));
        taken   = is_jump || (ex_target != ex_pc);
    end

    // Next-state: FSM, PC, flush counter and the event side outputs.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cnt_d            = cnt_q;
        link_addr_d      = link_addr_q;
        link_valid_d     = 1'b0;
        misaligned_d     = 1'b0;
        redirect_count_d = redirect_count_q;

        if (!stall) begin
            unique case (state_q)
                StBoot: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (ex_valid && taken) begin
                        state_d          = StFlush;
                        cnt_d            = CntW'(FLUSH_DEPTH);
                        redirect_count_d = redirect_count_q + 16'd1;
                        if (ex_target[1:0] == 2'b00) begin
                            pc_d = ex_target;
                        end else begin
                            pc_d         = TRAP_VECTOR;
                            misaligned_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + XLEN'(INSTR_BYTES);
                    end
                    if (ex_valid && is_jump) begin
                        link_addr_d  = ex_pc + XLEN'(INSTR_BYTES);
                        link_valid_d = 1'b1;
                    end
                end
                StFlush: begin
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StBoot;
            pc_q             <= RESET_VECTOR;
            cnt_q            <= '0;
            link_addr_q      <= '0;
            link_valid_q     <= 1'b0;
            misaligned_q     <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            cnt_q            <= cnt_d;
            link_addr_q      <= link_addr_d;
            link_valid_q     <= link_valid_d;
            misaligned_q     <= misaligned_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        pc_out         = pc_q;
        fetch_valid    = (state_q == StRun);
        flush          = (state_q == StFlush);
        link_addr      = link_addr_q;
        link_valid     = link_valid_q;
        misaligned     = misaligned_q;
        redirect_count = redirect_count_q;
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: cycle vector table through an expected-value queue,
// plus a hand-written asynchronous reset in the middle of a flush window.
module tb_branch_redirect_ctrl;
    import branch_redirect_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_operation;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [31:0] pc_out;
    logic        fetch_valid;
    logic        flush;
    logic [31:0] link_addr;
    logic        link_valid;
    logic        misaligned;
    logic [15:0] redirect_count;

    branch_redirect_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_operation   (ex_operation),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .pc_out         (pc_out),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .link_addr      (link_addr),
        .link_valid     (link_valid),
        .misaligned     (misaligned),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        lv;
        logic [31:0] la;
        logic        mis;
        logic [15:0] rc;
    } exp_t;

    typedef struct {
        logic        st;
        logic        ev;
        logic [2:0]  op;
        logic [31:0] xp;
        logic [31:0] xt;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t v(input logic st, input logic ev, input logic [2:0] op,
                               input logic [31:0] xp, input logic [31:0] xt,
                               input logic [31:0] pc, input logic fv, input logic fl,
                               input logic lv, input logic [31:0] la, input logic mis,
                               input logic [15:0] rc);
        vec_t r;
        r.st = st; r.ev = ev; r.op = op; r.xp = xp; r.xt = xt;
        r.e.pc = pc; r.e.fv = fv; r.e.fl = fl; r.e.lv = lv;
        r.e.la = la; r.e.mis = mis; r.e.rc = rc;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, idx, act, req);
        end
    endtask

    task automatic chk_all(input int idx, input exp_t e);
        chk("pc_out", idx, pc_out, e.pc);
        chk("fetch_valid", idx, 32'(fetch_valid), 32'(e.fv));
        chk("flush", idx, 32'(flush), 32'(e.fl));
        chk("link_valid", idx, 32'(link_valid), 32'(e.lv));
        chk("link_addr", idx, link_addr, e.la);
        chk("misaligned", idx, 32'(misaligned), 32'(e.mis));
        chk("redirect_count", idx, 32'(redirect_count), 32'(e.rc));
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input int idx, input vec_t t);
        exp_t e;
        stall        = t.st;
        ex_valid     = t.ev;
        ex_operation = t.op;
        ex_pc        = t.xp;
        ex_target    = t.xt;
        exp_q.push_back(t.e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard step %0d: queue empty, required one entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk_all(idx, e);
        end
    endtask

    exp_t rst_e;

    initial begin
        rst_e = '{pc: 32'h0, fv: 1'b0, fl: 1'b0, lv: 1'b0, la: 32'h0, mis: 1'b0, rc: 16'h0};

        //             st ev op      ex_pc         ex_target     pc_out        fv fl lv link_addr  mis rc
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h0,        1, 0, 0, 32'h0,     0, 0));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h4,        1, 0, 0, 32'h0,     0, 0));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h8,        1, 0, 0, 32'h0,     0, 0));
        vecs.push_back(v(0, 1, OpBeq,  32'h10,       32'h40,       32'h40,       0, 1, 0, 32'h0,     0, 1));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h40,       0, 1, 0, 32'h0,     0, 1));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h40,       1, 0, 0, 32'h0,     0, 1));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h44,       1, 0, 0, 32'h0,     0, 1));
        vecs.push_back(v(0, 1, OpBne,  32'h20,       32'h20,       32'h48,       1, 0, 0, 32'h0,     0, 1));
        vecs.push_back(v(0, 1, OpJal,  32'h30,       32'h80,       32'h80,       0, 1, 1, 32'h34,    0, 2));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h80,       0, 1, 0, 32'h34,    0, 2));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h80,       1, 0, 0, 32'h34,    0, 2));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h84,       1, 0, 0, 32'h34,    0, 2));
        vecs.push_back(v(0, 1, OpJalr, 32'h84,       32'h82,       32'h100,      0, 1, 1, 32'h88,    1, 3));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h100,      0, 1, 0, 32'h88,    0, 3));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h100,      1, 0, 0, 32'h88,    0, 3));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h104,      1, 0, 0, 32'h88,    0, 3));
        // Stalled in RUN: PC holds, ex_valid ignored.
        vecs.push_back(v(1, 1, OpBeq,  32'h0,        32'h200,      32'h104,      1, 0, 0, 32'h88,    0, 3));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h108,      1, 0, 0, 32'h88,    0, 3));
        // Flush window stretched by three stalls; ex_valid ignored throughout.
        vecs.push_back(v(0, 1, OpJal,  32'h108,      32'h200,      32'h200,      0, 1, 1, 32'h10c,   0, 4));
        vecs.push_back(v(1, 1, OpBeq,  32'h0,        32'h300,      32'h200,      0, 1, 0, 32'h10c,   0, 4));
        vecs.push_back(v(1, 0, OpBeq,  32'h0,        32'h0,        32'h200,      0, 1, 0, 32'h10c,   0, 4));
        vecs.push_back(v(1, 0, OpBeq,  32'h0,        32'h0,        32'h200,      0, 1, 0, 32'h10c,   0, 4));
        vecs.push_back(v(0, 1, OpBeq,  32'h4,        32'h400,      32'h200,      0, 1, 0, 32'h10c,   0, 4));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h200,      1, 0, 0, 32'h10c,   0, 4));
        // Address wrap of link address and sequential PC.
        vecs.push_back(v(0, 1, OpJal,  32'hffff_fffc, 32'hffff_fff8, 32'hffff_fff8, 0, 1, 1, 32'h0,   0, 5));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'hffff_fff8, 0, 1, 0, 32'h0,    0, 5));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'hffff_fff8, 1, 0, 0, 32'h0,    0, 5));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'hffff_fffc, 1, 0, 0, 32'h0,    0, 5));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h0,        1, 0, 0, 32'h0,     0, 5));
        // Misaligned conditional branch target traps without touching the link.
        vecs.push_back(v(0, 1, OpBltu, 32'h0,        32'h11,       32'h100,      0, 1, 0, 32'h0,     1, 6));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h100,      0, 1, 0, 32'h0,     0, 6));
        vecs.push_back(v(0, 0, OpBeq,  32'h0,        32'h0,        32'h100,      1, 0, 0, 32'h0,     0, 6));

        rst_n        = 1'b0;
        stall        = 1'b0;
        ex_valid     = 1'b0;
        ex_operation = 3'd0;
        ex_pc        = 32'h0;
        ex_target    = 32'h0;
        #12;
        chk_all(-1, rst_e);
        rst_n = 1'b1;

        foreach (vecs[i]) step(i, vecs[i]);

        // Reset asserted mid-flush, between clock edges, right after a JAL.
        step(100, v(0, 1, OpJal, 32'h100, 32'h500, 32'h500, 0, 1, 1, 32'h104, 0, 7));
        ex_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, rst_e);
        #3;
        rst_n = 1'b1;
        step(102, v(0, 0, OpBeq, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0));
        step(103, v(0, 0, OpBeq, 32'h0, 32'h0, 32'h4, 1, 0, 0, 32'h0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
